// File: rtl/tile_seq_ctrl_if.sv
// Command, operand, tile and result signals of the tile sequencer, bundled as one interface.
// The slave view is the sequencer itself; the master view is the surrounding logic plus the tile.
interface tile_seq_ctrl_if #(
    parameter int A_W     = 8,
    parameter int ACC_W   = 19,
    parameter int SHIFT_W = 5,
    parameter int LEN_W   = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [LEN_W-1:0]   cmd_len;
    logic [SHIFT_W-1:0] cmd_shift;
    logic [ACC_W-1:0]   cmd_d;

    logic               op_valid;
    logic               op_ready;
    logic [A_W-1:0]     op_a;
    logic [ACC_W-1:0]   op_b;

    logic [A_W-1:0]     tile_in_a;
    logic [ACC_W-1:0]   tile_in_b;
    logic [ACC_W-1:0]   tile_in_d;
    logic               tile_in_prop;
    logic [SHIFT_W-1:0] tile_in_shift;
    logic               tile_in_valid;
    logic [ACC_W-1:0]   tile_out_c;
    logic [ACC_W-1:0]   tile_out_b;
    logic               tile_out_valid;

    logic               res_valid;
    logic [ACC_W-1:0]   res_c;
    logic [ACC_W-1:0]   res_b;
    logic               res_last;
    logic               busy;
    logic               done;

    modport slave (
        input  cmd_valid, cmd_len, cmd_shift, cmd_d,
        input  op_valid, op_a, op_b,
        input  tile_out_c, tile_out_b, tile_out_valid,
        output cmd_ready, op_ready,
        output tile_in_a, tile_in_b, tile_in_d, tile_in_prop, tile_in_shift, tile_in_valid,
        output res_valid, res_c, res_b, res_last, busy, done
    );

    modport master (
        output cmd_valid, cmd_len, cmd_shift, cmd_d,
        output op_valid, op_a, op_b,
        output tile_out_c, tile_out_b, tile_out_valid,
        input  cmd_ready, op_ready,
        input  tile_in_a, tile_in_b, tile_in_d, tile_in_prop, tile_in_shift, tile_in_valid,
        input  res_valid, res_c, res_b, res_last, busy, done
    );
endinterface

// File: rtl/tile_seq_ctrl.sv
// Sequencer for one systolic tile: takes a command, streams K operand beats into the PE with
// propagate/shift/valid control, and counts the returning results into a result stream.
module tile_seq_ctrl #(
    parameter int A_W     = 8,
    parameter int ACC_W   = 19,
    parameter int SHIFT_W = 5,
    parameter int LEN_W   = 8
) (
    input logic           clock,
    input logic           reset_n,
    tile_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t             r_state, w_next;
    logic [LEN_W-1:0]   r_len, r_beat_cnt, r_ret_cnt;
    logic [SHIFT_W-1:0] r_shift;
    logic [ACC_W-1:0]   r_d;
    logic               r_prop, r_zero_done;

    logic [A_W-1:0]     r_in_a;
    logic [ACC_W-1:0]   r_in_b, r_in_d;
    logic [SHIFT_W-1:0] r_in_shift;
    logic               r_in_prop, r_in_valid;

    logic [LEN_W-1:0]   w_last_idx;
    logic               w_cmd_ready, w_op_ready, w_done;
    logic               w_cmd_acc, w_op_acc, w_res_valid;

    assign w_last_idx  = r_len - LEN_W'(1);
    assign w_cmd_acc   = bus.cmd_valid & w_cmd_ready;
    assign w_op_acc    = bus.op_valid & w_op_ready;
    // Results only count while a command is outstanding; extras past K are dropped.
    assign w_res_valid = bus.tile_out_valid & (r_state != S_IDLE) & (r_ret_cnt != r_len);

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_op_ready  = 1'b0;
        w_done      = r_zero_done;
        case (r_state)
            S_IDLE: begin
                // Held low during reset and during a zero-length done pulse.
                w_cmd_ready = reset_n & ~r_zero_done;
                if (bus.cmd_valid && w_cmd_ready && bus.cmd_len != '0)
                    w_next = S_STREAM;
            end
            S_STREAM: begin
                w_op_ready = 1'b1;
                if (bus.op_valid && r_beat_cnt == w_last_idx)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_ret_cnt == r_len) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_ret_cnt   <= '0;
            r_shift     <= '0;
            r_d         <= '0;
            r_prop      <= 1'b0;
            r_zero_done <= 1'b0;
            r_in_a      <= '0;
            r_in_b      <= '0;
            r_in_d      <= '0;
            r_in_shift  <= '0;
            r_in_prop   <= 1'b0;
            r_in_valid  <= 1'b0;
        end else begin
            r_zero_done <= w_cmd_acc && (bus.cmd_len == '0);
            if (w_cmd_acc) begin
                r_len      <= bus.cmd_len;
                r_shift    <= bus.cmd_shift;
                r_d        <= bus.cmd_d;
                r_beat_cnt <= '0;
                r_ret_cnt  <= '0;
                // Swap the PE's double-buffered accumulator once per real command.
                if (bus.cmd_len != '0)
                    r_prop <= ~r_prop;
            end
            r_in_valid <= w_op_acc;
            if (w_op_acc) begin
                r_in_a     <= bus.op_a;
                r_in_b     <= bus.op_b;
                r_in_shift <= r_shift;
                r_in_prop  <= r_prop;
                r_in_d     <= (r_beat_cnt == '0) ? r_d : '0;
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
            if (w_res_valid)
                r_ret_cnt <= r_ret_cnt + LEN_W'(1);
        end
    end

    assign bus.cmd_ready     = w_cmd_ready;
    assign bus.op_ready      = w_op_ready;
    assign bus.tile_in_a     = r_in_a;
    assign bus.tile_in_b     = r_in_b;
    assign bus.tile_in_d     = r_in_d;
    assign bus.tile_in_prop  = r_in_prop;
    assign bus.tile_in_shift = r_in_shift;
    assign bus.tile_in_valid = r_in_valid;
    assign bus.res_valid     = w_res_valid;
    assign bus.res_c         = bus.tile_out_c;
    assign bus.res_b         = bus.tile_out_b;
    assign bus.res_last      = w_res_valid & (r_ret_cnt == w_last_idx);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = w_done;
endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Scoreboard bench for tile_seq_ctrl: a one-cycle PE model closes the loop, expected results are
// queued as beats are accepted and a separate monitor pops and compares them.
module tb_tile_seq_ctrl;
    localparam int ACC_W = 19;

    typedef struct packed {
        logic [ACC_W-1:0] c;
        logic [ACC_W-1:0] b;
        logic             last;
    } res_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic inject  = 1'b0;
    always #5 clock = ~clock;

    tile_seq_ctrl_if bus ();
    tile_seq_ctrl dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    // PE model: out_c = d + a*b, out_b echoes shift/prop/a so control fields are visible in results.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.tile_out_valid <= 1'b0;
            bus.tile_out_c     <= '0;
            bus.tile_out_b     <= '0;
        end else begin
            bus.tile_out_valid <= bus.tile_in_valid | inject;
            bus.tile_out_c     <= {11'b0, bus.tile_in_a} * bus.tile_in_b + bus.tile_in_d;
            bus.tile_out_b     <= {bus.tile_in_shift, bus.tile_in_prop, 5'b0, bus.tile_in_a};
        end
    end

    int   n_cmp = 0, n_bad = 0;
    res_t sb[$];
    int   done_q[$];
    int   done_cnt = 0, vcount = 0, cyc = 0, last_res_cyc = 0, acc_cyc = 0;
    bit   in_cmd = 1'b0;
    logic exp_prop = 1'b0, cur_prop = 1'b0;
    logic [4:0] cur_shift = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares everything the DUT presents on the falling edge.
    initial forever begin
        @(negedge clock);
        cyc++;
        if (!reset_n) begin
            vcount = 0;
        end else begin
            if (in_cmd) check("cmd_ready_while_busy", bus.cmd_ready, 0);
            if (bus.tile_in_valid) begin
                vcount++;
                check("tile_in_prop", bus.tile_in_prop, cur_prop);
                check("tile_in_shift", bus.tile_in_shift, cur_shift);
            end
            if (bus.res_valid) begin
                if (sb.size() == 0) begin
                    check("res_unexpected", 1, 0);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    check("res_beat", {bus.res_c, bus.res_b, bus.res_last}, e);
                    if (bus.res_last) last_res_cyc = cyc;
                end
            end
            if (bus.done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    int k;
                    k = done_q.pop_front();
                    check("done_beat_count", vcount, k);
                    if (k == 0) check("done_latency_len0", cyc, acc_cyc + 1);
                    else        check("done_after_last", cyc, last_res_cyc + 1);
                end
                check("sb_empty_at_done", sb.size(), 0);
                vcount = 0;
                in_cmd = 1'b0;
            end
        end
    end

    // Issue one command and its beats; expectations come from the command fields alone.
    task automatic do_cmd(input int k, input int shift, input int d, input int gap_pct,
                          input int dir_gap, input bit seq_ops);
        int t, target;
        logic [7:0] a;
        logic [18:0] b, d_eff;
        res_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'(k);
        bus.cmd_shift = 5'(shift);
        bus.cmd_d     = 19'(d);
        t = 0;
        @(negedge clock);
        while (!bus.cmd_ready && t < 100) begin @(negedge clock); t++; end
        if (!bus.cmd_ready) begin
            check("cmd_accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        if (k != 0) exp_prop = ~exp_prop;
        cur_prop  = exp_prop;
        cur_shift = 5'(shift);
        done_q.push_back(k);
        target = done_cnt + 1;
        @(posedge clock); #1;
        acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
        in_cmd = 1'b1;
        for (int i = 0; i < k; i++) begin
            int idle;
            idle = (i == 1) ? dir_gap : 0;
            while ($urandom_range(99) < gap_pct) idle++;
            bus.op_valid = 1'b0;
            repeat (idle) begin @(posedge clock); #1; end
            a = seq_ops ? 8'(i + 1) : 8'($urandom);
            b = seq_ops ? 19'(10 * (i + 1)) : 19'($urandom);
            bus.op_valid = 1'b1;
            bus.op_a = a;
            bus.op_b = b;
            t = 0;
            @(negedge clock);
            while (!bus.op_ready && t < 50) begin @(negedge clock); t++; end
            if (!bus.op_ready) begin
                check("op_accept_timeout", 0, 1);
                bus.op_valid = 1'b0;
                return;
            end
            d_eff  = (i == 0) ? 19'(d) : 19'd0;
            e.c    = {11'b0, a} * b + d_eff;
            e.b    = {5'(shift), exp_prop, 5'b0, a};
            e.last = (i == k - 1);
            sb.push_back(e);
            @(posedge clock); #1;
        end
        bus.op_valid = 1'b0;
        t = 0;
        while (done_cnt < target && t < 100) begin @(posedge clock); #1; t++; end
        check("done_seen", done_cnt >= target, 1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_tile_in_valid"}, bus.tile_in_valid, 0);
        check({tag, "_tile_in_prop"}, bus.tile_in_prop, 0);
        check({tag, "_tile_in_d"}, bus.tile_in_d, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 0);
        check({tag, "_op_ready"}, bus.op_ready, 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_shift = '0; bus.cmd_d = '0;
        bus.op_valid  = 1'b0; bus.op_a = '0; bus.op_b = '0;
        repeat (2) @(posedge clock);
        #1;
        check_quiet("reset");
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("cmd_ready_idle", bus.cmd_ready, 1);

        do_cmd(3, 2, 5, 0, 0, 1'b1);
        do_cmd(1, 4, 100, 0, 0, 1'b0);
        do_cmd(1, 9, 200, 0, 0, 1'b0);
        do_cmd(3, 7, 9, 0, 2, 1'b0);
        do_cmd(0, 3, 77, 0, 0, 1'b0);

        // Stray tile_out_valid with no command outstanding must not surface.
        @(posedge clock); #1;
        inject = 1'b1;
        @(posedge clock); #1;
        inject = 1'b0;
        @(negedge clock);
        check("spurious_dropped", bus.res_valid, 0);
        @(posedge clock); #1;

        // Reset in the middle of a K=4 command, after two beats went in.
        bus.cmd_valid = 1'b1; bus.cmd_len = 8'd4; bus.cmd_shift = 5'd6; bus.cmd_d = 19'd3;
        @(negedge clock);
        check("cmd_ready_before_abort", bus.cmd_ready, 1);
        exp_prop = ~exp_prop;
        cur_prop = exp_prop;
        cur_shift = 5'd6;
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        bus.op_valid = 1'b1; bus.op_a = 8'd1; bus.op_b = 19'd2;
        repeat (2) begin @(posedge clock); #1; end
        bus.op_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_quiet("abort");
        sb.delete();
        done_q.delete();
        in_cmd = 1'b0;
        exp_prop = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(posedge clock); #1;
        do_cmd(2, 1, 11, 0, 0, 1'b0);
        check("prop_after_abort", bus.tile_in_prop, 1);

        do_cmd(255, 13, 1234, 0, 0, 1'b0);

        for (int n = 0; n < 25; n++)
            do_cmd(int'($urandom_range(0, 12)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 524287)), 30, 0, 1'b0);

        repeat (5) @(posedge clock);
        #1;
        check("sb_drained", sb.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1);
    end
endmodule
